// File: rtl/led_circ_ctrl.sv
// One-hot LED rotator driven by debounced run and mode keys; short mode press cycles speed, long press reverses.
// All outputs registered; run toggles 1 cycle after key rise, first step P cycles after running rises.
module led_circ_ctrl #(
    parameter int LED_W  = 8,
    parameter int TICK_N = 25_000_000,
    parameter int LONG_N = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_run,
    input  logic             key_mode,
    output logic [LED_W-1:0] led,
    output logic             running,
    output logic             dir,
    output logic [1:0]       speed,
    output logic             step_pulse
);

    localparam logic [31:0] TICK_C    = 32'(TICK_N);
    localparam logic [31:0] LONG_LAST = 32'(LONG_N - 1);
    localparam logic [LED_W-1:0] LED_RST = {{(LED_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HELD, LONG} mode_state_e;

    mode_state_e      state_q;
    logic [31:0]      hold_q;
    logic [31:0]      tick_q, tick_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             run_d_q;
    logic             running_q, running_d;
    logic             dir_q;
    logic [1:0]       speed_q;
    logic             step_q;

    logic [31:0]      period;
    logic             step;
    logic             short_press;
    logic             long_press;

    always_comb begin
        period      = TICK_C >> speed_q;
        step        = running_q && (tick_q == period - 32'd1);
        short_press = (state_q == HELD) && !key_mode;
        long_press  = (state_q == HELD) && key_mode && (hold_q == LONG_LAST);
        running_d   = running_q ^ (key_run & ~run_d_q);

        // A speed change restarts the count so the new period starts cleanly.
        tick_d = tick_q + 32'd1;
        if (!running_q || step || short_press) begin
            tick_d = '0;
        end

        led_d = led_q;
        if (step) begin
            led_d = dir_q ? {led_q[0], led_q[LED_W-1:1]}
                          : {led_q[LED_W-2:0], led_q[LED_W-1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_d_q   <= 1'b0;
            running_q <= 1'b0;
            tick_q    <= '0;
            led_q     <= LED_RST;
            step_q    <= 1'b0;
        end else begin
            run_d_q   <= key_run;
            running_q <= running_d;
            tick_q    <= tick_d;
            led_q     <= led_d;
            step_q    <= step;
        end
    end

    // Mode key FSM: dir/speed are its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            speed_q <= 2'd0;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_mode) begin
                        state_q <= HELD;
                        hold_q  <= 32'd1;
                    end
                end
                HELD: begin
                    if (short_press) begin
                        speed_q <= speed_q + 2'd1;
                        state_q <= IDLE;
                    end else if (long_press) begin
                        dir_q   <= ~dir_q;
                        state_q <= LONG;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                LONG: begin
                    if (!key_mode) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led        = led_q;
    assign running    = running_q;
    assign dir        = dir_q;
    assign speed      = speed_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_led_circ_ctrl.sv
// Bench for led_circ_ctrl: expected LED steps queued with their cycle, popped when step_pulse fires.
module tb_led_circ_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_run;
    logic       key_mode;
    logic [7:0] led;
    logic       running;
    logic       dir;
    logic [1:0] speed;
    logic       step_pulse;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [7:0] led;
    } step_t;

    step_t exp_q[$];
    step_t mon_e;

    led_circ_ctrl #(.LED_W(8), .TICK_N(16), .LONG_N(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_run    (key_run),
        .key_mode   (key_mode),
        .led        (led),
        .running    (running),
        .dir        (dir),
        .speed      (speed),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_step(input int c, input logic [7:0] l);
        step_t e;
        e.cyc = c;
        e.led = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press_run(input logic exp_run, output int r);
        key_run = 1'b1;
        @(negedge clk);
        r = cyc;
        chk("run_toggle", running, exp_run);
        repeat (2) @(negedge clk);
        key_run = 1'b0;
    endtask

    task automatic press_mode(input int n);
        key_mode = 1'b1;
        repeat (n) @(negedge clk);
        key_mode = 1'b0;
    endtask

    // Step monitor: each pulse must match the oldest expectation in cycle and pattern.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                chk("step_missing", cyc, mon_e.cyc);
            end
            if (step_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("step_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("step_cycle", cyc, mon_e.cyc);
                    chk("step_led", led, mon_e.led);
                end
            end
        end
    end

    initial begin
        int r, rp, r2, s, L;
        reset    = 1'b1;
        key_run  = 1'b0;
        key_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_led", led, 8'h01);
        chk("rst_running", running, 0);
        chk("rst_dir", dir, 0);
        chk("rst_speed", speed, 0);
        chk("rst_step", step_pulse, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Run start, two-plus steps at speed 0, then pause at 0x08.
        press_run(1'b1, r);
        push_step(r + 16, 8'h02);
        push_step(r + 32, 8'h04);
        push_step(r + 48, 8'h08);
        wait_until(r + 50);
        press_run(1'b0, rp);
        wait_until(rp + 100);
        chk("pause_led", led, 8'h08);
        chk("pause_running", running, 0);

        // Four short presses while paused walk speed around to 0.
        for (int i = 1; i <= 4; i++) begin
            press_mode(2);
            @(negedge clk);
            chk("speed_cycle", speed, 32'(i % 4));
            @(negedge clk);
        end

        // Resume: first step 16 cycles later, then a 5-cycle press halves the period.
        press_run(1'b1, r2);
        push_step(r2 + 16, 8'h10);
        wait_until(r2 + 16);
        press_mode(5);
        @(negedge clk);
        chk("short_speed", speed, 1);
        s = cyc;
        push_step(s + 8, 8'h20);
        push_step(s + 16, 8'h40);
        push_step(s + 24, 8'h80);
        push_step(s + 32, 8'h01);
        wait_until(s + 32);

        // Long press: dir flips on the 20th high sample, once only.
        L = cyc;
        push_step(L + 8, 8'h02);
        push_step(L + 16, 8'h04);
        push_step(L + 24, 8'h02);
        push_step(L + 32, 8'h01);
        push_step(L + 40, 8'h80);
        push_step(L + 48, 8'h40);
        key_mode = 1'b1;
        wait_until(L + 19);
        chk("long_before", dir, 0);
        wait_until(L + 20);
        chk("long_toggle", dir, 1);
        wait_until(L + 30);
        chk("long_once", dir, 1);
        key_mode = 1'b0;
        wait_until(L + 32);
        chk("long_release_dir", dir, 1);
        chk("long_release_speed", speed, 1);

        // Reach speed 2, dir 1, led 0x20, then reset mid-count.
        wait_until(L + 48);
        press_mode(2);
        push_step(L + 55, 8'h20);
        wait_until(L + 57);
        chk("pre_rst_speed", speed, 2);
        chk("pre_rst_dir", dir, 1);
        chk("pre_rst_led", led, 8'h20);
        chk("pre_rst_running", running, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_led", led, 8'h01);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_dir", dir, 0);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_step", step_pulse, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/led_circ_ctrl.md
# led_circ_ctrl

Sequencer for the LED-circulate design: consumes the debounced key levels produced by the key debounce filters and drives a one-hot rotating LED pattern. It toggles run/pause, cycles step speed, and reverses direction. Short and long presses on the mode key are distinguished by hold time. It sits between the two debounce filter instances and the board LED pins.

## Interface
- `LED_W`, 8: number of LEDs, and width of the one-hot pattern (≥2).
- `TICK_N`, 25_000_000: clock cycles per LED step at speed 0. Must be ≥8 and a multiple of 8.
- `LONG_N`, 50_000_000: hold cycles on `key_mode` that make a long press (≥2).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `key_run` in 1: debounced run/pause key level, 1 = pressed.
- `key_mode` in 1: debounced mode key level, 1 = pressed.
- `led` out `LED_W`: one-hot LED pattern.
- `running` out 1: 1 = pattern advancing, 0 = paused.
- `dir` out 1: 0 = rotate toward MSB, 1 = rotate toward LSB.
- `speed` out 2: speed index 0..3; 3 is fastest.
- `step_pulse` out 1: one-cycle pulse on each LED rotation.

## Operation
- Reset values:
  - `led` = 1 (bit 0 lit).
  - `running` = 0, `dir` = 0, `speed` = 0, `step_pulse` = 0.
  - Internal key delay registers = 0, tick counter = 0, hold counter = 0, mode FSM = IDLE.
  - Reset asserted mid-operation returns everything to these values immediately.
- Run key: register `key_run` once (`run_d`). A rising edge (`key_run & ~run_d`) toggles `running`.
  - A key held high through reset release counts as an edge, because `run_d` resets to 0.
- Mode key FSM, hold counter 32-bit:
  - IDLE: if `key_mode`=1, go to HELD and set hold count to 1.
  - HELD, `key_mode`=0: short press. Set `speed` ← `speed`+1 mod 4, tick counter ← 0, go to IDLE.
  - HELD, `key_mode`=1 and hold count = `LONG_N`-1: long press. Toggle `dir`, go to LONG. Speed is unchanged.
  - HELD, otherwise: increment the hold count.
  - LONG: if `key_mode`=0, go to IDLE with no further action. A long press fires exactly once.
- Step timer:
  - Period P = `TICK_N` >> `speed`, giving `TICK_N`, /2, /4, /8.
  - While `running`=1, the tick counter counts 0..P-1.
  - At P-1 the counter clears, `led` rotates one position in direction `dir` with wrap (MSB→bit0 for dir 0, bit0→MSB for dir 1), and `step_pulse`=1 for that cycle.
  - While `running`=0, the tick counter is held at 0 and `led` is frozen.
  - A pause never loses the LED position.
- Simultaneous events:
  - Run edge and mode event in the same cycle: both take effect.
  - Step and `dir` toggle in the same cycle: the step uses the old `dir`, and the new `dir` applies from the next step.
  - Step and speed change in the same cycle: the step happens, the counter clears, and the new P applies from the next count.
  - Pausing in the same cycle as a step: the step happens and the counter clears.
- `speed` wraps 3→0. `dir` and `speed` stay changeable while paused.

## Timing
- `running` changes on the clock edge that samples `key_run`=1 with `run_d`=0, i.e. 1 cycle after the input rises.
- First step after a run start: `step_pulse` and the `led` change occur P cycles after `running` goes high. Subsequent steps occur every P cycles.
- Short press: `speed` updates on the edge that samples `key_mode`=0 in HELD, 1 cycle after the input falls.
- Long press: `dir` toggles on the edge ending the `LONG_N`-th consecutive high sample of `key_mode`.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
Use `TICK_N`=16 and `LONG_N`=20 for simulation.
- Reset, then hold `key_run` high 3 cycles: `running`=1 one cycle after the rise; `led` goes 0x01→0x02 after 16 cycles, →0x04 after 32; `step_pulse` pulses once per step.
- Running at 0x80 with dir 0: the next step gives 0x01 (wrap). With dir 1, 0x01 gives 0x80.
- Mode key held 5 cycles: `speed` becomes 1 and the step period becomes 8. Four short presses from speed 0 return `speed` to 0.
- Mode key held 30 cycles: `dir` toggles exactly once at the 20th high cycle; `speed` is unchanged on release.
- Press `key_run` again while at 0x08: `running`=0 and `led` stays 0x08 for 100 cycles. Resume: the next step comes 16 cycles later.
- Assert `reset` mid-count with speed 2, dir 1, `led`=0x20: all outputs return to their reset values in the same cycle.
